// File: rtl/rv32_pkg.sv
// Shared RV32 types for the memory stage: op/size encodings, FSM states and the
// misalignment rule used by both the aligner and the stage controller.
package rv32_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_op_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } mem_size_e;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_REQ  = 2'd1,
        MS_WAIT = 2'd2
    } mem_state_e;

    // Unknown size encodings are treated as word accesses.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = off[0];
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational byte-lane logic: store enables/replication, misalign detect, and
// load extraction with sign/zero extension.
module lsu_align
    import rv32_pkg::*;
(
    input  logic [1:0]  i_st_size,
    input  logic [1:0]  i_st_addr_lo,
    input  logic [31:0] i_st_data,
    output logic [3:0]  o_st_be,
    output logic [31:0] o_st_wdata,
    output logic        o_misalign,
    input  logic [1:0]  i_ld_size,
    input  logic [1:0]  i_ld_addr_lo,
    input  logic        i_ld_unsigned,
    input  logic [31:0] i_ld_rdata,
    output logic [31:0] o_ld_data
);

    logic [31:0] w_ld_shifted;

    assign o_misalign   = is_misaligned(i_st_size, i_st_addr_lo);
    // Aligned loads only reach here, so a byte-granular shift serves halves too.
    assign w_ld_shifted = i_ld_rdata >> {i_ld_addr_lo, 3'b000};

    // Store lane enables and lane-replicated write data.
    always_comb begin
        o_st_be    = 4'b0000;
        o_st_wdata = 32'h0000_0000;
        case (i_st_size)
            SZ_B: begin
                o_st_be    = 4'b0001 << i_st_addr_lo;
                o_st_wdata = {4{i_st_data[7:0]}};
            end
            SZ_H: begin
                o_st_be    = 4'b0011 << {i_st_addr_lo[1], 1'b0};
                o_st_wdata = {2{i_st_data[15:0]}};
            end
            default: begin
                o_st_be    = 4'b1111;
                o_st_wdata = i_st_data;
            end
        endcase
    end

    // Load extraction and extension.
    always_comb begin
        o_ld_data = 32'h0000_0000;
        case (i_ld_size)
            SZ_B: begin
                if (i_ld_unsigned) begin
                    o_ld_data = {24'h00_0000, w_ld_shifted[7:0]};
                end else begin
                    o_ld_data = {{24{w_ld_shifted[7]}}, w_ld_shifted[7:0]};
                end
            end
            SZ_H: begin
                if (i_ld_unsigned) begin
                    o_ld_data = {16'h0000, w_ld_shifted[15:0]};
                end else begin
                    o_ld_data = {{16{w_ld_shifted[15]}}, w_ld_shifted[15:0]};
                end
            end
            default: o_ld_data = i_ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: one outstanding data-bus access over req/gnt/rvalid, EX stalled
// while it is in flight, and a registered one-cycle writeback packet.
module mem_stage
    import rv32_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid_i,
    output logic                  ex_ready_o,
    input  logic [DATA_WIDTH-1:0] alu_res_i,
    input  logic [DATA_WIDTH-1:0] store_data_i,
    input  logic [1:0]            mem_op_i,
    input  logic [1:0]            mem_size_i,
    input  logic                  mem_unsigned_i,
    input  logic [4:0]            rd_addr_i,
    input  logic                  rd_we_i,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [ADDR_WIDTH-1:0] dmem_addr_o,
    output logic [3:0]            dmem_be_o,
    output logic [DATA_WIDTH-1:0] dmem_wdata_o,
    input  logic                  dmem_gnt_i,
    input  logic                  dmem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
    output logic                  wb_valid_o,
    output logic [4:0]            wb_rd_o,
    output logic                  wb_we_o,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    output logic                  misalign_o
);

    mem_state_e            r_state;
    mem_state_e            w_next_state;
    logic                  r_dmem_req;
    logic                  r_dmem_we;
    logic [ADDR_WIDTH-1:0] r_dmem_addr;
    logic [3:0]            r_dmem_be;
    logic [DATA_WIDTH-1:0] r_dmem_wdata;
    logic                  r_wb_valid;
    logic [4:0]            r_wb_rd;
    logic                  r_wb_we;
    logic [DATA_WIDTH-1:0] r_wb_data;
    logic                  r_misalign;
    logic                  r_rd_we;
    logic [1:0]            r_ld_size;
    logic [1:0]            r_ld_off;
    logic                  r_ld_uns;

    logic                  w_accept;
    logic                  w_is_mem;
    logic                  w_misalign;
    logic [3:0]            w_st_be;
    logic [31:0]           w_st_wdata;
    logic [31:0]           w_ld_data;

    assign w_accept = ex_valid_i & (r_state == MS_IDLE);
    assign w_is_mem = (mem_op_i == MEM_LOAD) | (mem_op_i == MEM_STORE);

    lsu_align u_align (
        .i_st_size     (mem_size_i),
        .i_st_addr_lo  (alu_res_i[1:0]),
        .i_st_data     (store_data_i),
        .o_st_be       (w_st_be),
        .o_st_wdata    (w_st_wdata),
        .o_misalign    (w_misalign),
        .i_ld_size     (r_ld_size),
        .i_ld_addr_lo  (r_ld_off),
        .i_ld_unsigned (r_ld_uns),
        .i_ld_rdata    (dmem_rdata_i),
        .o_ld_data     (w_ld_data)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= MS_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; a store leaves REQ straight to IDLE, a load waits for data.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            MS_IDLE: begin
                if (w_accept & w_is_mem & ~w_misalign) w_next_state = MS_REQ;
                else                                   w_next_state = MS_IDLE;
            end
            MS_REQ: begin
                if (dmem_gnt_i) w_next_state = r_dmem_we ? MS_IDLE : MS_WAIT;
                else            w_next_state = MS_REQ;
            end
            MS_WAIT: begin
                if (dmem_rvalid_i) w_next_state = MS_IDLE;
                else               w_next_state = MS_WAIT;
            end
            default: w_next_state = MS_IDLE;
        endcase
    end

    // Bus request fields, captured load context and writeback packet.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_be    <= 4'b0000;
            r_dmem_wdata <= '0;
            r_wb_valid   <= 1'b0;
            r_wb_rd      <= 5'd0;
            r_wb_we      <= 1'b0;
            r_wb_data    <= '0;
            r_misalign   <= 1'b0;
            r_rd_we      <= 1'b0;
            r_ld_size    <= 2'b00;
            r_ld_off     <= 2'b00;
            r_ld_uns     <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_wb_we    <= 1'b0;
            r_misalign <= 1'b0;
            case (r_state)
                MS_IDLE: begin
                    if (w_accept) begin
                        r_wb_rd   <= rd_addr_i;
                        r_rd_we   <= rd_we_i & (rd_addr_i != 5'd0);
                        r_ld_size <= mem_size_i;
                        r_ld_off  <= alu_res_i[1:0];
                        r_ld_uns  <= mem_unsigned_i;
                        if (!w_is_mem) begin
                            r_wb_valid <= 1'b1;
                            r_wb_we    <= rd_we_i & (rd_addr_i != 5'd0);
                            r_wb_data  <= alu_res_i;
                        end else if (w_misalign) begin
                            r_wb_valid <= 1'b1;
                            r_misalign <= 1'b1;
                            r_wb_data  <= alu_res_i;
                        end else begin
                            r_dmem_req   <= 1'b1;
                            r_dmem_we    <= (mem_op_i == MEM_STORE);
                            r_dmem_addr  <= {alu_res_i[ADDR_WIDTH-1:2], 2'b00};
                            r_dmem_be    <= w_st_be;
                            r_dmem_wdata <= w_st_wdata;
                        end
                    end
                end
                MS_REQ: begin
                    if (dmem_gnt_i) begin
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        if (r_dmem_we) begin
                            r_wb_valid <= 1'b1;
                            r_wb_data  <= '0;
                        end
                    end
                end
                MS_WAIT: begin
                    if (dmem_rvalid_i) begin
                        r_wb_valid <= 1'b1;
                        r_wb_we    <= r_rd_we;
                        r_wb_data  <= w_ld_data;
                    end
                end
                default: r_dmem_req <= 1'b0;
            endcase
        end
    end

    assign ex_ready_o   = (r_state == MS_IDLE);
    assign dmem_req_o   = r_dmem_req;
    assign dmem_we_o    = r_dmem_we;
    assign dmem_addr_o  = r_dmem_addr;
    assign dmem_be_o    = r_dmem_be;
    assign dmem_wdata_o = r_dmem_wdata;
    assign wb_valid_o   = r_wb_valid;
    assign wb_rd_o      = r_wb_rd;
    assign wb_we_o      = r_wb_we;
    assign wb_data_o    = r_wb_data;
    assign misalign_o   = r_misalign;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed ops push expected writebacks, a monitor
// pops and compares on every wb_valid_o pulse.
module tb_mem_stage;
    import rv32_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid_i;
    logic        ex_ready_o;
    logic [31:0] alu_res_i;
    logic [31:0] store_data_i;
    logic [1:0]  mem_op_i;
    logic [1:0]  mem_size_i;
    logic        mem_unsigned_i;
    logic [4:0]  rd_addr_i;
    logic        rd_we_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic        wb_we_o;
    logic [31:0] wb_data_o;
    logic        misalign_o;

    always #5 clk = ~clk;

    mem_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
        .alu_res_i(alu_res_i), .store_data_i(store_data_i), .mem_op_i(mem_op_i),
        .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i), .rd_addr_i(rd_addr_i),
        .rd_we_i(rd_we_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_we_o(wb_we_o),
        .wb_data_o(wb_data_o), .misalign_o(misalign_o)
    );

    typedef struct {
        logic [4:0]  rd;
        logic        chk_rd;
        logic        we;
        logic [31:0] data;
        logic        chk_data;
        logic        mis;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   rc;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [4:0] rd, input logic chk_rd, input logic we,
                                input logic [31:0] data, input logic chk_data, input logic mis);
        exp_t e;
        e.rd = rd; e.chk_rd = chk_rd; e.we = we;
        e.data = data; e.chk_data = chk_data; e.mis = mis;
        return e;
    endfunction

    // Monitor: every writeback pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst && wb_valid_o) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: got wb_valid=1 expected no writeback");
            end else begin
                mon_e = sb_q.pop_front();
                chk1("wb_we", wb_we_o, mon_e.we);
                chk1("wb_misalign", misalign_o, mon_e.mis);
                if (mon_e.chk_data) chk32("wb_data", wb_data_o, mon_e.data);
                if (mon_e.chk_rd) chk32("wb_rd", {27'd0, wb_rd_o}, {27'd0, mon_e.rd});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
                         input logic rdwe, input logic push, input exp_t e);
        int n;
        n = 0;
        while (!ex_ready_o && n < 50) begin
            step();
            n++;
        end
        if (!ex_ready_o) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ex_ready=0 expected 1 within 50 cycles");
        end
        mem_op_i = op; mem_size_i = sz; mem_unsigned_i = uns;
        alu_res_i = a; store_data_i = sd; rd_addr_i = rd; rd_we_i = rdwe;
        ex_valid_i = 1'b1;
        if (push) sb_q.push_back(e);
        step();
        ex_valid_i = 1'b0;
    endtask

    // Bus slave: grant after gnt_dly cycles, then for loads return data rv_dly cycles later.
    task automatic do_bus(input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                          input logic is_load, output int req_cycles);
        logic [31:0] a0;
        a0 = dmem_addr_o;
        req_cycles = 0;
        for (int i = 0; i < gnt_dly; i++) begin
            if (dmem_req_o) req_cycles++;
            step();
        end
        if (dmem_req_o) req_cycles++;
        chk32("req_addr_stable", dmem_addr_o, a0);
        dmem_gnt_i = 1'b1;
        step();
        dmem_gnt_i = 1'b0;
        chk1("req_drop_after_gnt", dmem_req_o, 1'b0);
        if (is_load) begin
            for (int i = 0; i < rv_dly - 1; i++) begin
                chk1("ex_ready_stall", ex_ready_o, 1'b0);
                step();
            end
            chk1("ex_ready_stall", ex_ready_o, 1'b0);
            dmem_rvalid_i = 1'b1;
            dmem_rdata_i  = rdata;
            step();
            dmem_rvalid_i = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b0; ex_valid_i = 1'b0; alu_res_i = 32'd0; store_data_i = 32'd0;
        mem_op_i = MEM_NONE; mem_size_i = SZ_W; mem_unsigned_i = 1'b0;
        rd_addr_i = 5'd0; rd_we_i = 1'b0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
        dmem_rdata_i = 32'd0;
        repeat (2) step();
        chk1("rst_ex_ready", ex_ready_o, 1'b1);
        chk1("rst_req", dmem_req_o, 1'b0);
        chk1("rst_wb_valid", wb_valid_o, 1'b0);
        chk32("rst_wb_data", wb_data_o, 32'd0);
        rst = 1'b1;
        step();

        // ALU pass-through, then two back-to-back (second has rd=x0).
        issue(MEM_NONE, SZ_W, 1'b0, 32'h0000_1234, 32'd0, 5'd5, 1'b1, 1'b1,
              mk(5'd5, 1'b1, 1'b1, 32'h0000_1234, 1'b1, 1'b0));
        chk1("none_no_req", dmem_req_o, 1'b0);
        issue(MEM_NONE, SZ_W, 1'b0, 32'h0000_0055, 32'd0, 5'd0, 1'b1, 1'b1,
              mk(5'd0, 1'b1, 1'b0, 32'h0000_0055, 1'b1, 1'b0));
        issue(MEM_NONE, SZ_W, 1'b0, 32'hCAFE_F00D, 32'd0, 5'd31, 1'b1, 1'b1,
              mk(5'd31, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b1, 1'b0));

        // SB 0x103, grant after 2 cycles.
        issue(MEM_STORE, SZ_B, 1'b0, 32'h0000_0103, 32'h0000_00AB, 5'd3, 1'b0, 1'b1,
              mk(5'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0));
        chk1("sb_req", dmem_req_o, 1'b1);
        chk1("sb_we", dmem_we_o, 1'b1);
        chk32("sb_addr", dmem_addr_o, 32'h0000_0100);
        chk32("sb_be", {28'd0, dmem_be_o}, 32'h0000_0008);
        chk32("sb_wdata", dmem_wdata_o, 32'hABAB_ABAB);
        chk1("sb_stall", ex_ready_o, 1'b0);
        do_bus(2, 0, 32'd0, 1'b0, rc);
        chk32("sb_req_cycles", rc, 32'd3);

        // LB / LBU 0x102.
        issue(MEM_LOAD, SZ_B, 1'b0, 32'h0000_0102, 32'd0, 5'd7, 1'b1, 1'b1,
              mk(5'd7, 1'b1, 1'b1, 32'hFFFF_FF80, 1'b1, 1'b0));
        chk32("lb_be", {28'd0, dmem_be_o}, 32'h0000_0004);
        chk1("lb_we", dmem_we_o, 1'b0);
        chk32("lb_addr", dmem_addr_o, 32'h0000_0100);
        do_bus(0, 1, 32'h0080_0000, 1'b1, rc);
        issue(MEM_LOAD, SZ_B, 1'b1, 32'h0000_0102, 32'd0, 5'd7, 1'b1, 1'b1,
              mk(5'd7, 1'b1, 1'b1, 32'h0000_0080, 1'b1, 1'b0));
        do_bus(0, 1, 32'h0080_0000, 1'b1, rc);

        // Misaligned LW 0x006 and SH 0x201: no bus request.
        issue(MEM_LOAD, SZ_W, 1'b0, 32'h0000_0006, 32'd0, 5'd8, 1'b1, 1'b1,
              mk(5'd8, 1'b0, 1'b0, 32'h0000_0006, 1'b1, 1'b1));
        chk1("lw_mis_no_req", dmem_req_o, 1'b0);
        step();
        chk1("lw_mis_no_req2", dmem_req_o, 1'b0);
        issue(MEM_STORE, SZ_H, 1'b0, 32'h0000_0201, 32'h1111_2222, 5'd0, 1'b0, 1'b1,
              mk(5'd0, 1'b0, 1'b0, 32'h0000_0201, 1'b1, 1'b1));
        chk1("sh_mis_no_req", dmem_req_o, 1'b0);

        // LH 0x202, immediate grant, data 4 cycles later.
        issue(MEM_LOAD, SZ_H, 1'b0, 32'h0000_0202, 32'd0, 5'd9, 1'b1, 1'b1,
              mk(5'd9, 1'b1, 1'b1, 32'hFFFF_8001, 1'b1, 1'b0));
        chk32("lh_be", {28'd0, dmem_be_o}, 32'h0000_000C);
        do_bus(0, 4, 32'h8001_0000, 1'b1, rc);

        // LHU 0x200 low half.
        issue(MEM_LOAD, SZ_H, 1'b1, 32'h0000_0200, 32'd0, 5'd10, 1'b1, 1'b1,
              mk(5'd10, 1'b1, 1'b1, 32'h0000_F00D, 1'b1, 1'b0));
        do_bus(0, 2, 32'h1234_F00D, 1'b1, rc);

        // SH 0x002 and SW 0x104.
        issue(MEM_STORE, SZ_H, 1'b0, 32'h0000_0002, 32'h1234_ABCD, 5'd0, 1'b0, 1'b1,
              mk(5'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0));
        chk32("sh_be", {28'd0, dmem_be_o}, 32'h0000_000C);
        chk32("sh_wdata", dmem_wdata_o, 32'hABCD_ABCD);
        chk32("sh_addr", dmem_addr_o, 32'h0000_0000);
        do_bus(1, 0, 32'd0, 1'b0, rc);
        chk32("sh_req_cycles", rc, 32'd2);
        issue(MEM_STORE, SZ_W, 1'b0, 32'h0000_0104, 32'h1122_3344, 5'd0, 1'b0, 1'b1,
              mk(5'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0));
        chk32("sw_be", {28'd0, dmem_be_o}, 32'h0000_000F);
        chk32("sw_wdata", dmem_wdata_o, 32'h1122_3344);
        chk32("sw_addr", dmem_addr_o, 32'h0000_0104);
        do_bus(0, 0, 32'd0, 1'b0, rc);
        chk32("sw_req_cycles", rc, 32'd1);

        // LW to x0: data returned but no register write.
        issue(MEM_LOAD, SZ_W, 1'b0, 32'h0000_0010, 32'd0, 5'd0, 1'b1, 1'b1,
              mk(5'd0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0));
        do_bus(0, 1, 32'hDEAD_BEEF, 1'b1, rc);

        // Reset while waiting for read data; the late rvalid must be dropped.
        issue(MEM_LOAD, SZ_W, 1'b0, 32'h0000_0300, 32'd0, 5'd11, 1'b1, 1'b0,
              mk(5'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0));
        dmem_gnt_i = 1'b1;
        step();
        dmem_gnt_i = 1'b0;
        chk1("wait_stall", ex_ready_o, 1'b0);
        rst = 1'b0;
        #1;
        chk1("arst_ex_ready", ex_ready_o, 1'b1);
        chk1("arst_req", dmem_req_o, 1'b0);
        chk1("arst_wb_valid", wb_valid_o, 1'b0);
        chk32("arst_be", {28'd0, dmem_be_o}, 32'd0);
        step();
        rst = 1'b1;
        step();
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h5A5A_5A5A;
        step();
        dmem_rvalid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk1("post_rst_wb_valid", wb_valid_o, 1'b0);
            chk1("post_rst_ex_ready", ex_ready_o, 1'b1);
            chk32("post_rst_wb_data", wb_data_o, 32'd0);
            step();
        end

        repeat (3) step();
        chk32("sb_drained", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
